pll_reset_sequencer: RTL and testbench

- Sequences the system PLL wrapper: drives its `rst` input, qualifies its `locked` output, and releases the synchronous-logic reset (`sys_rst`) only after a stable lock.
- Retries the PLL on lock timeout, re-sequences on loss of lock or software relock request, and latches a fault after exhausting retries.
- Sits between the board reference clock/reset pin and the PLL plus core reset tree.

---
 rtl/pll_seq_pkg.sv | 15 +
 rtl/pll_lock_sync.sv | 15 +
 rtl/pll_reset_sequencer.sv | 78 +++++++
 tb/tb_pll_reset_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, default timing constants and counter sizing for the PLL reset sequencer.
package pll_seq_pkg;
  typedef enum logic [2:0] {PLLRST, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_MAX_RETRIES  = 3;
  localparam int DEF_SYNC_STAGES  = 2;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: STAGES-deep flop synchronizer bringing the asynchronous PLL lock into the refclk domain.
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic refclk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge refclk or posedge rst)
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL reset, qualifies lock and releases sys_rst after stable lock; retries, then faults.
// Optional PLL_LOCK_LOSS_CNT_EN adds an 8-bit saturating count of lock losses seen in RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);
  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(LOCK_STABLE - 1);
  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_lock;
  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .refclk(refclk),
    .rst   (rst),
    .i_d   (pll_locked),
    .o_q   (w_lock)
  );
  // lock beats timeout in WAIT_LOCK; unknown encodings fall into FAULT
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      PLLRST:    w_nxt = (r_cnt == RST_LAST) ? WAIT_LOCK : PLLRST;
      WAIT_LOCK: w_nxt = w_lock ? STABLE : (r_cnt != TO_LAST) ? WAIT_LOCK :
                         (retry_cnt == 3'(MAX_RETRIES)) ? FAULT : PLLRST;
      STABLE:    w_nxt = !w_lock ? WAIT_LOCK : (r_cnt == ST_LAST) ? RUN : STABLE;
      RUN:       w_nxt = (!w_lock || relock_req) ? PLLRST : RUN;
      default:   w_nxt = FAULT;
    endcase
  end
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state   <= PLLRST;
      r_cnt     <= '0;
      retry_cnt <= 3'd0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
`ifdef PLL_LOCK_LOSS_CNT_EN
      lock_loss_cnt <= 8'd0;
`endif
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= (w_nxt != r_state) ? '0 : r_cnt + CW'(1);
      retry_cnt <= (w_nxt == RUN) ? 3'd0 :
                   (r_state == WAIT_LOCK && w_nxt == PLLRST) ? retry_cnt + 3'd1 : retry_cnt;
      pll_rst   <= (w_nxt == PLLRST) || (w_nxt == FAULT);
      sys_rst   <= w_nxt != RUN;
      ready     <= w_nxt == RUN;
      fault     <= w_nxt == FAULT;
`ifdef PLL_LOCK_LOSS_CNT_EN
      if (r_state == RUN && !w_lock && lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 8'd1;
`endif
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed vector table, async-reset corner case and random stimulus against a reference model.
module tb_pll_reset_sequencer;
  localparam int RC = 4, TO = 20, ST = 8, MR = 2, SS = 2;
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAULT = 4;
  logic refclk = 1'b0;
  logic rst = 1'b0;
  logic pll_locked = 1'b0;
  logic relock_req = 1'b0;
  logic pll_rst, sys_rst, ready, fault;
  logic [2:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
  int llc;
`endif
  int n_chk = 0, n_pass = 0;
  int mode, t, retries;
  bit hist[$];
  typedef struct {
    logic rs; logic lk; logic rq; int n;
    logic pr; logic sr; logic rd; logic ft; logic [2:0] rc;
  } vec_t;
  vec_t vt[$];
  pll_reset_sequencer #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .LOCK_STABLE(ST), .MAX_RETRIES(MR), .SYNC_STAGES(SS)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault), .retry_cnt(retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );
  always #5 refclk = ~refclk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic model_reset();
    hist.delete();
    mode = M_RST; t = 0; retries = 0;
`ifdef PLL_LOCK_LOSS_CNT_EN
    llc = 0;
`endif
  endtask
  // lock_s seen at an edge is the pll_locked value sampled SS edges earlier
  task automatic model_step();
    bit ls;
    ls = (hist.size() >= SS) ? hist[hist.size() - SS] : 1'b0;
    hist.push_back(pll_locked);
    if (hist.size() > 16) hist.delete(0);
    case (mode)
      M_RST: begin t++; if (t == RC) begin mode = M_WAIT; t = 0; end end
      M_WAIT:
        if (ls) begin mode = M_STAB; t = 0; end
        else begin
          t++;
          if (t == TO) begin
            t = 0;
            if (retries == MR) mode = M_FAULT;
            else begin retries++; mode = M_RST; end
          end
        end
      M_STAB:
        if (!ls) begin mode = M_WAIT; t = 0; end
        else begin t++; if (t == ST) begin mode = M_RUN; retries = 0; end end
      M_RUN:
        if (!ls || relock_req) begin
`ifdef PLL_LOCK_LOSS_CNT_EN
          if (!ls && llc < 255) llc++;
`endif
          mode = M_RST; t = 0;
        end
      default: ;
    endcase
  endtask
  task automatic model_check();
    chk("pll_rst", int'(pll_rst), int'(mode == M_RST || mode == M_FAULT));
    chk("sys_rst", int'(sys_rst), int'(mode != M_RUN));
    chk("ready", int'(ready), int'(mode == M_RUN));
    chk("fault", int'(fault), int'(mode == M_FAULT));
    chk("retry_cnt", int'(retry_cnt), retries);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("lock_loss_cnt", int'(lock_loss_cnt), llc);
`endif
  endtask
  task automatic tick(input logic lk, input logic rq);
    pll_locked = lk;
    relock_req = rq;
    @(posedge refclk);
    model_step();
    #1 model_check();
  endtask
  // asserts rst between edges, checks the asynchronous reset values, releases on a falling edge
  task automatic apply_reset();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    #1;
    model_reset();
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_sys_rst", int'(sys_rst), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_retry_cnt", int'(retry_cnt), 0);
    @(negedge refclk);
    rst = 1'b0;
  endtask
  initial begin
    logic lkr;
    // clean start, loss of lock in RUN, relock_req in RUN and while locking
    vt.push_back('{1,0,0, 3, 1,1,0,0,0});
    vt.push_back('{0,0,0, 1, 0,1,0,0,0});
    vt.push_back('{0,0,0, 3, 0,1,0,0,0});
    vt.push_back('{0,1,0,10, 0,1,0,0,0});
    vt.push_back('{0,1,0, 1, 0,0,1,0,0});
    vt.push_back('{0,0,0, 2, 0,0,1,0,0});
    vt.push_back('{0,0,0, 1, 1,1,0,0,0});
    vt.push_back('{0,1,0, 3, 1,1,0,0,0});
    vt.push_back('{0,1,0, 1, 0,1,0,0,0});
    vt.push_back('{0,1,0, 8, 0,1,0,0,0});
    vt.push_back('{0,1,0, 1, 0,0,1,0,0});
    vt.push_back('{0,1,1, 1, 1,1,0,0,0});
    vt.push_back('{0,1,0, 3, 1,1,0,0,0});
    vt.push_back('{0,1,0, 1, 0,1,0,0,0});
    vt.push_back('{0,1,1, 1, 0,1,0,0,0});
    vt.push_back('{0,1,0, 7, 0,1,0,0,0});
    vt.push_back('{0,1,0, 1, 0,0,1,0,0});
    // glitchy lock with an ignored relock_req in WAIT_LOCK
    vt.push_back('{1,0,0, 4, 0,1,0,0,0});
    vt.push_back('{0,1,1, 1, 0,1,0,0,0});
    vt.push_back('{0,1,0, 4, 0,1,0,0,0});
    vt.push_back('{0,0,0, 1, 0,1,0,0,0});
    vt.push_back('{0,1,0,10, 0,1,0,0,0});
    vt.push_back('{0,1,0, 1, 0,0,1,0,0});
    // never lock: two retries then terminal fault
    vt.push_back('{1,0,0, 3, 1,1,0,0,0});
    vt.push_back('{0,0,0, 1, 0,1,0,0,0});
    vt.push_back('{0,0,0,19, 0,1,0,0,0});
    vt.push_back('{0,0,0, 1, 1,1,0,0,1});
    vt.push_back('{0,0,0, 3, 1,1,0,0,1});
    vt.push_back('{0,0,0, 1, 0,1,0,0,1});
    vt.push_back('{0,0,0,19, 0,1,0,0,1});
    vt.push_back('{0,0,0, 1, 1,1,0,0,2});
    vt.push_back('{0,0,0,23, 0,1,0,0,2});
    vt.push_back('{0,0,0, 1, 1,1,0,1,2});
    vt.push_back('{0,1,1,30, 1,1,0,1,2});
    #2;
    foreach (vt[i]) begin
      if (vt[i].rs) apply_reset();
      repeat (vt[i].n) tick(vt[i].lk, vt[i].rq);
      chk($sformatf("row%0d_pll_rst", i), int'(pll_rst), int'(vt[i].pr));
      chk($sformatf("row%0d_sys_rst", i), int'(sys_rst), int'(vt[i].sr));
      chk($sformatf("row%0d_ready", i), int'(ready), int'(vt[i].rd));
      chk($sformatf("row%0d_fault", i), int'(fault), int'(vt[i].ft));
      chk($sformatf("row%0d_retry_cnt", i), int'(retry_cnt), int'(vt[i].rc));
`ifdef PLL_LOCK_LOSS_CNT_EN
      if (i == 16) chk("row16_lock_loss_cnt", int'(lock_loss_cnt), 1);
`endif
    end
    // asynchronous reset while in STABLE, then a fresh sequence
    apply_reset();
    repeat (7) tick(1'b1, 1'b0);
    chk("stable_sys_rst", int'(sys_rst), 1);
    chk("stable_pll_rst", int'(pll_rst), 0);
    #2;
    apply_reset();
    repeat (4) tick(1'b1, 1'b0);
    chk("restart_pll_rst", int'(pll_rst), 0);
    repeat (12) tick(1'b1, 1'b0);
    chk("restart_ready", int'(ready), 1);
    // random lock behaviour, relock requests and occasional resets
    apply_reset();
    lkr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      if ($urandom_range(0, 29) == 0) lkr = ~lkr;
      tick(lkr, $urandom_range(0, 49) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
